// File: rtl/xalu_arb.sv
// xalu_arb: round-robin arbiter sharing one ISE custom-op ALU between two
// requesters, with one registered response slot per port.
//
// Ports (N = 0,1):
//   ise_clk, ise_rst       clock, synchronous active-high reset
//   rqN_val/rdy            request handshake (rdy is the combinational grant)
//   rqN_fn/imm/in1/in2/tag request fields
//   rsN_val/rdy            response handshake
//   rsN_out/err/tag        registered response (err = ALU did not claim op)
//   alu_val/fn/imm/in1/in2 drive to the shared ALU (zeroed when idle)
//   alu_oval, alu_out      combinational ALU claim and result
//   err_cnt                saturating count of error responses
module xalu_arb #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        ise_clk,
    input  logic        ise_rst,

    input  logic        rq0_val,
    output logic        rq0_rdy,
    input  logic [5:0]  rq0_fn,
    input  logic [6:0]  rq0_imm,
    input  logic [63:0] rq0_in1,
    input  logic [63:0] rq0_in2,
    input  logic [3:0]  rq0_tag,
    output logic        rs0_val,
    input  logic        rs0_rdy,
    output logic [63:0] rs0_out,
    output logic        rs0_err,
    output logic [3:0]  rs0_tag,

    input  logic        rq1_val,
    output logic        rq1_rdy,
    input  logic [5:0]  rq1_fn,
    input  logic [6:0]  rq1_imm,
    input  logic [63:0] rq1_in1,
    input  logic [63:0] rq1_in2,
    input  logic [3:0]  rq1_tag,
    output logic        rs1_val,
    input  logic        rs1_rdy,
    output logic [63:0] rs1_out,
    output logic        rs1_err,
    output logic [3:0]  rs1_tag,

    output logic        alu_val,
    output logic [5:0]  alu_fn,
    output logic [6:0]  alu_imm,
    output logic [63:0] alu_in1,
    output logic [63:0] alu_in2,
    input  logic        alu_oval,
    input  logic [63:0] alu_out,

    output logic [15:0] err_cnt
);

    logic prio;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic cap_err;

    // A slot draining this cycle can take a new result on the same edge.
    assign elig0 = rq0_val & (~rs0_val | rs0_rdy);
    assign elig1 = rq1_val & (~rs1_val | rs1_rdy);

    // prio names the port that wins a tie.
    assign gnt0 = ~ise_rst & elig0 & (~elig1 | ~prio);
    assign gnt1 = ~ise_rst & elig1 & (~elig0 | prio);

    assign rq0_rdy = gnt0;
    assign rq1_rdy = gnt1;

    // Operands are forced to zero when idle so the ALU inputs stay quiet.
    always_comb begin
        alu_val = 1'b0;
        alu_fn  = '0;
        alu_imm = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (gnt0) begin
            alu_val = 1'b1;
            alu_fn  = rq0_fn;
            alu_imm = rq0_imm;
            alu_in1 = rq0_in1;
            alu_in2 = rq0_in2;
        end else if (gnt1) begin
            alu_val = 1'b1;
            alu_fn  = rq1_fn;
            alu_imm = rq1_imm;
            alu_in1 = rq1_in1;
            alu_in2 = rq1_in2;
        end
    end

    assign cap_err = (gnt0 | gnt1) & ~alu_oval;

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            prio <= RR_INIT;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            rs0_val <= 1'b0;
            rs0_out <= '0;
            rs0_err <= 1'b0;
            rs0_tag <= '0;
        end else if (gnt0) begin
            rs0_val <= 1'b1;
            rs0_out <= alu_out;
            rs0_err <= ~alu_oval;
            rs0_tag <= rq0_tag;
        end else if (rs0_val & rs0_rdy) begin
            rs0_val <= 1'b0;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            rs1_val <= 1'b0;
            rs1_out <= '0;
            rs1_err <= 1'b0;
            rs1_tag <= '0;
        end else if (gnt1) begin
            rs1_val <= 1'b1;
            rs1_out <= alu_out;
            rs1_err <= ~alu_oval;
            rs1_tag <= rq1_tag;
        end else if (rs1_val & rs1_rdy) begin
            rs1_val <= 1'b0;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            err_cnt <= '0;
        end else if (cap_err && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_xalu_arb.sv
// tb_xalu_arb: directed plus randomized bench for xalu_arb with a
// transaction-level reference model and an XOR stand-in ALU.
module tb_xalu_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       rq_val = '0;
    logic [1:0]       rs_rdy = '0;
    logic [1:0][5:0]  rq_fn  = '0;
    logic [1:0][6:0]  rq_imm = '0;
    logic [1:0][63:0] rq_in1 = '0;
    logic [1:0][63:0] rq_in2 = '0;
    logic [1:0][3:0]  rq_tag = '0;

    wire [1:0]       rq_rdy;
    wire [1:0]       rs_val;
    wire [1:0]       rs_err;
    wire [1:0][63:0] rs_out;
    wire [1:0][3:0]  rs_tag;

    wire        alu_val;
    wire [5:0]  alu_fn;
    wire [6:0]  alu_imm;
    wire [63:0] alu_in1;
    wire [63:0] alu_in2;
    wire        alu_oval;
    wire [63:0] alu_out;
    wire [15:0] err_cnt;

    assign alu_out  = alu_in1 ^ alu_in2;
    assign alu_oval = (alu_fn != 6'h3F);

    xalu_arb #(.RR_INIT(1'b0)) dut (
        .ise_clk (clk),
        .ise_rst (rst),
        .rq0_val (rq_val[0]),
        .rq0_rdy (rq_rdy[0]),
        .rq0_fn  (rq_fn[0]),
        .rq0_imm (rq_imm[0]),
        .rq0_in1 (rq_in1[0]),
        .rq0_in2 (rq_in2[0]),
        .rq0_tag (rq_tag[0]),
        .rs0_val (rs_val[0]),
        .rs0_rdy (rs_rdy[0]),
        .rs0_out (rs_out[0]),
        .rs0_err (rs_err[0]),
        .rs0_tag (rs_tag[0]),
        .rq1_val (rq_val[1]),
        .rq1_rdy (rq_rdy[1]),
        .rq1_fn  (rq_fn[1]),
        .rq1_imm (rq_imm[1]),
        .rq1_in1 (rq_in1[1]),
        .rq1_in2 (rq_in2[1]),
        .rq1_tag (rq_tag[1]),
        .rs1_val (rs_val[1]),
        .rs1_rdy (rs_rdy[1]),
        .rs1_out (rs_out[1]),
        .rs1_err (rs_err[1]),
        .rs1_tag (rs_tag[1]),
        .alu_val (alu_val),
        .alu_fn  (alu_fn),
        .alu_imm (alu_imm),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .alu_oval(alu_oval),
        .alu_out (alu_out),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one result slot per port, tie winner, error total.
    logic [1:0]       m_val  = '0;
    logic [1:0][63:0] m_out  = '0;
    logic [1:0]       m_err  = '0;
    logic [1:0][3:0]  m_tag  = '0;
    int               m_tie  = 0;
    longint           m_cnt  = 0;
    logic [1:0]       last_g = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check at negedge, then advance the model at posedge.
    task automatic step();
        int w;
        bit el [2];
        @(negedge clk);
        for (int p = 0; p < 2; p++)
            el[p] = rq_val[p] && (!m_val[p] || rs_rdy[p]);
        w = -1;
        if (!rst) begin
            if (el[0] && el[1]) w = m_tie;
            else if (el[0]) w = 0;
            else if (el[1]) w = 1;
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rq%0d_rdy", p), 64'(rq_rdy[p]), 64'(w == p));
            chk($sformatf("rs%0d_val", p), 64'(rs_val[p]), 64'(m_val[p]));
            chk($sformatf("rs%0d_out", p), rs_out[p], m_out[p]);
            chk($sformatf("rs%0d_err", p), 64'(rs_err[p]), 64'(m_err[p]));
            chk($sformatf("rs%0d_tag", p), 64'(rs_tag[p]), 64'(m_tag[p]));
        end
        chk("alu_val", 64'(alu_val), 64'(w >= 0));
        chk("alu_fn", 64'(alu_fn), (w >= 0) ? 64'(rq_fn[w]) : 64'd0);
        chk("alu_imm", 64'(alu_imm), (w >= 0) ? 64'(rq_imm[w]) : 64'd0);
        chk("alu_in1", alu_in1, (w >= 0) ? rq_in1[w] : 64'd0);
        chk("alu_in2", alu_in2, (w >= 0) ? rq_in2[w] : 64'd0);
        chk("err_cnt", 64'(err_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
        last_g = rq_rdy;
        @(posedge clk);
        if (rst) begin
            m_val = '0;
            m_out = '0;
            m_err = '0;
            m_tag = '0;
            m_tie = 0;
            m_cnt = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w == p) begin
                    m_val[p] = 1'b1;
                    m_out[p] = rq_in1[p] ^ rq_in2[p];
                    m_err[p] = (rq_fn[p] == 6'h3F);
                    m_tag[p] = rq_tag[p];
                    if (rq_fn[p] == 6'h3F) m_cnt++;
                end else if (m_val[p] && rs_rdy[p]) begin
                    m_val[p] = 1'b0;
                end
            end
            if (w >= 0) m_tie = 1 - w;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit seen;

        // Reset with a request asserted: must not be granted.
        rq_val = 2'b11;
        rs_rdy = 2'b11;
        step();
        step();
        rst = 1'b0;
        rq_val = 2'b00;

        // Idle: ALU held quiet.
        rq_in1[0] = 64'hDEAD_BEEF;
        rq_in2[1] = 64'h1234_5678;
        for (int i = 0; i < 4; i++) step();
        chk("idle_in1", alu_in1, 64'd0);
        chk("idle_in2", alu_in2, 64'd0);

        // Single op on port 0.
        rq_val = 2'b01;
        rq_fn[0] = 6'h03;
        rq_in1[0] = 64'hF0;
        rq_in2[0] = 64'h0F;
        rq_tag[0] = 4'd5;
        step();
        chk("t1_rdy", 64'(last_g[0]), 64'd1);
        rq_val = 2'b00;
        chk("t1_val", 64'(rs_val[0]), 64'd1);
        chk("t1_out", rs_out[0], 64'hFF);
        chk("t1_tag", 64'(rs_tag[0]), 64'd5);
        chk("t1_err", 64'(rs_err[0]), 64'd0);
        step();

        // Tie: alternating grants starting at port 0.
        do_reset();
        rq_val = 2'b11;
        rs_rdy = 2'b11;
        rq_fn = '0;
        for (int i = 0; i < 4; i++) begin
            rq_tag[0] = 4'(i);
            rq_tag[1] = 4'(8 + i);
            rq_in1[0] = {$urandom, $urandom};
            rq_in1[1] = {$urandom, $urandom};
            step();
            chk("t2_grant", 64'(last_g), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Backpressure on port 1.
        rs_rdy = 2'b01;
        for (int i = 0; i < 6; i++) step();
        chk("t3_blk1", 64'(last_g[1]), 64'd0);
        chk("t3_run0", 64'(last_g[0]), 64'd1);
        rs_rdy = 2'b11;
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            seen = last_g[1];
        end
        chk("t3_release", 64'(seen), 64'd1);
        rq_val = 2'b00;
        step();

        // Single error op.
        chk("t4_cnt0", 64'(err_cnt), 64'd0);
        rq_val = 2'b01;
        rq_fn[0] = 6'h3F;
        step();
        rq_val = 2'b00;
        chk("t4_err", 64'(rs_err[0]), 64'd1);
        chk("t4_cnt1", 64'(err_cnt), 64'd1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                rq_val[p] = ($urandom_range(0, 3) != 0);
                rs_rdy[p] = ($urandom_range(0, 3) != 0);
                rq_fn[p]  = 6'($urandom_range(0, 63));
                rq_imm[p] = 7'($urandom);
                rq_in1[p] = {$urandom, $urandom};
                rq_in2[p] = {$urandom, $urandom};
                rq_tag[p] = 4'($urandom);
            end
            step();
        end

        // Saturation.
        rq_val = 2'b11;
        rs_rdy = 2'b11;
        rq_fn[0] = 6'h3F;
        rq_fn[1] = 6'h3F;
        for (int i = 0; i < 65540; i++) step();
        chk("t4_sat", 64'(err_cnt), 64'hFFFF);

        // Reset mid-flight with port 1 holding a result.
        rq_val = 2'b10;
        rs_rdy = 2'b00;
        rq_fn[1] = 6'h01;
        step();
        chk("t5_pend", 64'(rs_val[1]), 64'd1);
        rq_val = 2'b11;
        do_reset();
        chk("t5_val1", 64'(rs_val[1]), 64'd0);
        chk("t5_cnt", 64'(err_cnt), 64'd0);
        rs_rdy = 2'b11;
        step();
        chk("t5_tie", 64'(last_g), 64'd1);
        rq_val = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
